// File: rtl/free_list_recover_ctrl_pkg.sv
// Shared rename/recovery definitions: FSM state encodings, width helpers and default configuration.
package free_list_recover_ctrl_pkg;

    localparam int unsigned PHY_REG_NUM_DEF  = 64;
    localparam int unsigned RENAME_WIDTH_DEF = 4;
    localparam int unsigned COMMIT_WIDTH_DEF = 4;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_RESTORE = 2'd2;
    localparam logic [1:0] ST_RESUME  = 2'd3;

    // Pointer width indexes PHY_REG_NUM entries; count width must also hold PHY_REG_NUM itself.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/free_list_recover_ctrl_rename_grant_arb.sv
// In-order prefix grant: lane i is granted only if lanes 0..i all request and i+1 entries are free.
module rename_grant_arb
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 7
)(
    input  logic [WIDTH-1:0] req,
    input  logic [CW-1:0]    avail_cnt,
    output logic [WIDTH-1:0] grant
);

    logic prefix_ok;

    always_comb begin
        grant     = '0;
        prefix_ok = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            prefix_ok = prefix_ok & req[i] & (32'(avail_cnt) > i);
            grant[i]  = prefix_ok;
        end
    end

endmodule

// File: rtl/free_list_recover_ctrl.sv
// Speculative free-list recovery controller: rename grant gating, flush drain/restore FSM, stall counter.
module free_list_recover_ctrl
    import free_list_recover_ctrl_pkg::*;
#(
    parameter  int unsigned PHY_REG_NUM  = PHY_REG_NUM_DEF,
    parameter  int unsigned RENAME_WIDTH = RENAME_WIDTH_DEF,
    localparam int unsigned PW           = ptr_width(PHY_REG_NUM),
    localparam int unsigned CW           = cnt_width(PHY_REG_NUM)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic [PW-1:0]           arch_head_i,
    input  logic [PW-1:0]           arch_tail_i,
    input  logic [CW-1:0]           arch_cnt_i,
    input  logic [CW-1:0]           spec_cnt_i,
    input  logic [RENAME_WIDTH-1:0] rename_req_i,
    output logic [RENAME_WIDTH-1:0] rename_grant_o,
    output logic                    rename_stall_o,
    output logic                    restore_o,
    output logic [PW-1:0]           restore_head_o,
    output logic [PW-1:0]           restore_tail_o,
    output logic [CW-1:0]           restore_cnt_o,
    output logic                    busy_o,
    output logic [31:0]             stall_cycles_o
);

    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic [PW-1:0]           head_q;
    logic [PW-1:0]           tail_q;
    logic [CW-1:0]           cnt_q;
    logic [31:0]             stall_cnt_q;
    logic                    capture_c;
    logic                    restore_c;
    logic                    grant_en_c;
    logic [RENAME_WIDTH-1:0] arb_grant;
    logic [RENAME_WIDTH-1:0] grant_c;
    logic                    stall_c;

    rename_grant_arb #(
        .WIDTH (RENAME_WIDTH),
        .CW    (CW)
    ) u_arb (
        .req       (rename_req_i),
        .avail_cnt (spec_cnt_i),
        .grant     (arb_grant)
    );

    // Next state plus zero-latency grant/restore qualifiers; any flush restarts the drain.
    always_comb begin
        state_d    = state_q;
        capture_c  = 1'b0;
        restore_c  = 1'b0;
        grant_en_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                grant_en_c = ~flush_i;
                if (flush_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                capture_c = ~flush_i;
                state_d   = flush_i ? ST_DRAIN : ST_RESTORE;
            end
            ST_RESTORE: begin
                restore_c = ~flush_i;
                state_d   = flush_i ? ST_DRAIN : ST_RESUME;
            end
            ST_RESUME: begin
                state_d = flush_i ? ST_DRAIN : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        grant_c = grant_en_c ? arb_grant : '0;
        stall_c = |(rename_req_i & ~grant_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Architectural snapshot taken once the last commit frees have settled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= CW'(PHY_REG_NUM);
        end else if (capture_c) begin
            head_q <= arch_head_i;
            tail_q <= arch_tail_i;
            cnt_q  <= arch_cnt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign rename_grant_o = grant_c;
    assign rename_stall_o = stall_c;
    assign restore_o      = restore_c;
    assign restore_head_o = head_q;
    assign restore_tail_o = tail_q;
    assign restore_cnt_o  = cnt_q;
    assign busy_o         = (state_q != ST_RUN);
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_free_list_recover_ctrl.sv
// Directed bench for free_list_recover_ctrl: grants, flush recovery timing, reset abort, stall saturation.
module tb_free_list_recover_ctrl;

    localparam int unsigned PHY_REG_NUM  = 64;
    localparam int unsigned RENAME_WIDTH = 4;
    localparam int unsigned PW           = 6;
    localparam int unsigned CW           = 7;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    flush_i;
    logic [PW-1:0]           arch_head_i;
    logic [PW-1:0]           arch_tail_i;
    logic [CW-1:0]           arch_cnt_i;
    logic [CW-1:0]           spec_cnt_i;
    logic [RENAME_WIDTH-1:0] rename_req_i;
    logic [RENAME_WIDTH-1:0] rename_grant_o;
    logic                    rename_stall_o;
    logic                    restore_o;
    logic [PW-1:0]           restore_head_o;
    logic [PW-1:0]           restore_tail_o;
    logic [CW-1:0]           restore_cnt_o;
    logic                    busy_o;
    logic [31:0]             stall_cycles_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    free_list_recover_ctrl #(
        .PHY_REG_NUM  (PHY_REG_NUM),
        .RENAME_WIDTH (RENAME_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .arch_head_i    (arch_head_i),
        .arch_tail_i    (arch_tail_i),
        .arch_cnt_i     (arch_cnt_i),
        .spec_cnt_i     (spec_cnt_i),
        .rename_req_i   (rename_req_i),
        .rename_grant_o (rename_grant_o),
        .rename_stall_o (rename_stall_o),
        .restore_o      (restore_o),
        .restore_head_o (restore_head_o),
        .restore_tail_o (restore_tail_o),
        .restore_cnt_o  (restore_cnt_o),
        .busy_o         (busy_o),
        .stall_cycles_o (stall_cycles_o)
    );

    // Advance one rising edge, then return at the following falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b1;
        arch_head_i = '0; arch_tail_i = '0; arch_cnt_i = '0;
        spec_cnt_i = '0; rename_req_i = '0;
        next_cycle();
        next_cycle();
        flush_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (restore_o !== 1'b0) begin errors++; $display("FAIL reset_restore: got %b expected 0", restore_o); end
        checks++; if (restore_cnt_o !== 7'd64) begin errors++; $display("FAIL reset_cnt: got %0d expected 64", restore_cnt_o); end
        checks++; if (restore_head_o !== 6'd0 || restore_tail_o !== 6'd0) begin errors++; $display("FAIL reset_ptrs: got %0d/%0d expected 0/0", restore_head_o, restore_tail_o); end
        checks++; if (stall_cycles_o !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cycles_o); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_partial_grant();
        rename_req_i = 4'b1111; spec_cnt_i = 7'd2;
        #1;
        checks++; if (rename_grant_o !== 4'b0011) begin errors++; $display("FAIL partial_grant: got %b expected 0011", rename_grant_o); end
        checks++; if (rename_stall_o !== 1'b1) begin errors++; $display("FAIL partial_stall: got %b expected 1", rename_stall_o); end
        next_cycle();
        checks++; if (stall_cycles_o !== 32'd1) begin errors++; $display("FAIL stall_cnt_inc: got %0d expected 1", stall_cycles_o); end
        rename_req_i = 4'b0000;
        next_cycle();
        checks++; if (stall_cycles_o !== 32'd1) begin errors++; $display("FAIL stall_cnt_hold: got %0d expected 1", stall_cycles_o); end
    endtask

    task automatic test_grant_patterns();
        logic [3:0] reqs [5]   = '{4'b1011, 4'b1111, 4'b1111, 4'b0111, 4'b0000};
        logic [6:0] cnts [5]   = '{7'd10,   7'd0,    7'd4,    7'd9,    7'd3};
        logic [3:0] grants [5] = '{4'b0011, 4'b0000, 4'b1111, 4'b0111, 4'b0000};
        logic       stalls [5] = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0};
        for (int k = 0; k < 5; k++) begin
            rename_req_i = reqs[k]; spec_cnt_i = cnts[k];
            #1;
            checks++; if (rename_grant_o !== grants[k]) begin errors++; $display("FAIL grant_pattern_%0d: got %b expected %b", k, rename_grant_o, grants[k]); end
            checks++; if (rename_stall_o !== stalls[k]) begin errors++; $display("FAIL stall_pattern_%0d: got %b expected %b", k, rename_stall_o, stalls[k]); end
            next_cycle();
        end
    endtask

    task automatic test_flush_recovery();
        rename_req_i = 4'b1111; spec_cnt_i = 7'd4;
        flush_i = 1'b1;
        #1;
        checks++; if (rename_grant_o !== 4'b0000) begin errors++; $display("FAIL flush_t_grant: got %b expected 0000", rename_grant_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_t_busy: got %b expected 0", busy_o); end
        next_cycle();
        flush_i = 1'b0; arch_head_i = 6'd5; arch_tail_i = 6'd9; arch_cnt_i = 7'd60;
        #1;
        checks++; if (busy_o !== 1'b1 || rename_grant_o !== 4'b0000 || restore_o !== 1'b0) begin errors++; $display("FAIL drain_cycle: got busy=%b grant=%b restore=%b expected 1/0000/0", busy_o, rename_grant_o, restore_o); end
        next_cycle();
        arch_head_i = 6'd1; arch_tail_i = 6'd2; arch_cnt_i = 7'd3;
        #1;
        checks++; if (restore_o !== 1'b1) begin errors++; $display("FAIL restore_pulse: got %b expected 1", restore_o); end
        checks++; if (restore_head_o !== 6'd5 || restore_tail_o !== 6'd9 || restore_cnt_o !== 7'd60) begin errors++; $display("FAIL restore_vals: got %0d/%0d/%0d expected 5/9/60", restore_head_o, restore_tail_o, restore_cnt_o); end
        checks++; if (busy_o !== 1'b1 || rename_grant_o !== 4'b0000) begin errors++; $display("FAIL restore_busy_grant: got busy=%b grant=%b expected 1/0000", busy_o, rename_grant_o); end
        next_cycle();
        #1;
        checks++; if (restore_o !== 1'b0 || busy_o !== 1'b1 || rename_grant_o !== 4'b0000) begin errors++; $display("FAIL resume_cycle: got restore=%b busy=%b grant=%b expected 0/1/0000", restore_o, busy_o, rename_grant_o); end
        checks++; if (restore_cnt_o !== 7'd60 || restore_head_o !== 6'd5) begin errors++; $display("FAIL restore_hold: got cnt=%0d head=%0d expected 60/5", restore_cnt_o, restore_head_o); end
        next_cycle();
        #1;
        checks++; if (busy_o !== 1'b0 || rename_grant_o !== 4'b1111) begin errors++; $display("FAIL run_after_recover: got busy=%b grant=%b expected 0/1111", busy_o, rename_grant_o); end
        rename_req_i = 4'b0000;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        next_cycle();
        flush_i = 1'b1;
        #1;
        checks++; if (restore_o !== 1'b0) begin errors++; $display("FAIL b2b_suppress: got %b expected 0", restore_o); end
        next_cycle();
        flush_i = 1'b0; arch_head_i = 6'd7; arch_tail_i = 6'd3; arch_cnt_i = 7'd12;
        #1;
        checks++; if (busy_o !== 1'b1 || restore_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy=%b restore=%b expected 1/0", busy_o, restore_o); end
        next_cycle();
        #1;
        checks++; if (restore_o !== 1'b1 || restore_head_o !== 6'd7 || restore_tail_o !== 6'd3 || restore_cnt_o !== 7'd12) begin errors++; $display("FAIL b2b_restore: got %b %0d/%0d/%0d expected 1 7/3/12", restore_o, restore_head_o, restore_tail_o, restore_cnt_o); end
        next_cycle();
        next_cycle();
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_back_to_run: got busy=%b expected 0", busy_o); end
    endtask

    task automatic test_reset_during_restore();
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0; arch_head_i = 6'd11; arch_tail_i = 6'd22; arch_cnt_i = 7'd33;
        next_cycle();
        #1;
        checks++; if (restore_o !== 1'b1 || restore_cnt_o !== 7'd33) begin errors++; $display("FAIL rst_pre_restore: got %b cnt=%0d expected 1/33", restore_o, restore_cnt_o); end
        rst_n = 1'b0;
        next_cycle();
        #1;
        checks++; if (restore_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_abort: got restore=%b busy=%b expected 0/0", restore_o, busy_o); end
        checks++; if (restore_cnt_o !== 7'd64 || restore_head_o !== 6'd0 || restore_tail_o !== 6'd0) begin errors++; $display("FAIL rst_capture: got %0d/%0d/%0d expected 0/0/64", restore_head_o, restore_tail_o, restore_cnt_o); end
        rst_n = 1'b1;
        next_cycle();
        #1;
        checks++; if (restore_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_no_late_pulse: got restore=%b busy=%b expected 0/0", restore_o, busy_o); end
    endtask

    task automatic test_stall_saturation();
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        rename_req_i = 4'b1111; spec_cnt_i = 7'd0;
        next_cycle();
        checks++; if (stall_cycles_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffffffff", stall_cycles_o); end
        next_cycle();
        next_cycle();
        checks++; if (stall_cycles_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffffffff", stall_cycles_o); end
        rename_req_i = 4'b0000;
        next_cycle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_partial_grant();
        test_grant_patterns();
        test_flush_recovery();
        test_back_to_back();
        test_reset_during_restore();
        test_stall_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
